// File: rtl/polaris_pkg.sv
// Shared Polaris execution-stage definitions: default datapath width and
// the state encoding of the iterative divider.
package polaris_pkg;

    localparam int XLEN = 64;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_RUN  = 2'd1,
        DIV_FIX  = 2'd2
    } div_state_e;

endpackage : polaris_pkg

// File: rtl/div_negate.sv
// Conditional two's-complement: passes value_i through, or negates it when
// enable_i is set. Used for operand magnitudes and for result sign fix-up.
module div_negate #(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] value_i,
    input  logic             enable_i,
    output logic [WIDTH-1:0] result_o
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    assign result_o = enable_i ? (~value_i + ONE) : value_i;

endmodule : div_negate

// File: rtl/divider.sv
// Iterative restoring divider, one quotient bit per clock. Signed operands
// are reduced to magnitudes up front and the recorded signs are re-applied
// to the quotient and remainder when the loop retires.
module divider
    import polaris_pkg::*;
#(
    parameter int WIDTH = XLEN
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    input  logic             start_i,
    input  logic             signed_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic             busy_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o,
    output logic             dzflag_o,
    output logic             vflag_o
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    div_state_e       state_q, state_d;
    logic [WIDTH-1:0] rem_q, rem_d;      // partial remainder (upper half of shift register)
    logic [WIDTH-1:0] quo_q, quo_d;      // dividend shifting out, quotient shifting in
    logic [WIDTH-1:0] dvs_q, dvs_d;      // divisor magnitude
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             q_neg_q, q_neg_d;
    logic             r_neg_q, r_neg_d;
    logic             dz_q, dz_d;
    logic             ov_q, ov_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dzflag_q, dzflag_d;
    logic             vflag_q, vflag_d;
    logic             valid_q, valid_d;

    logic [WIDTH-1:0] dvd_mag, dvs_mag;
    logic [WIDTH:0]   shifted;
    logic             fits;
    logic [WIDTH-1:0] step_rem, step_quo;
    logic [WIDTH-1:0] quo_fix, rem_fix;

    div_negate #(.WIDTH(WIDTH)) u_neg_dividend (
        .value_i  (dividend_i),
        .enable_i (signed_i & dividend_i[WIDTH-1]),
        .result_o (dvd_mag)
    );

    div_negate #(.WIDTH(WIDTH)) u_neg_divisor (
        .value_i  (divisor_i),
        .enable_i (signed_i & divisor_i[WIDTH-1]),
        .result_o (dvs_mag)
    );

    // One restoring step: the partial remainder gains the next dividend bit,
    // then the divisor is subtracted only if it fits. The shifted value is
    // WIDTH+1 bits wide, so the compare is done at that width; when it fits
    // the difference is below the divisor and its low WIDTH bits are exact.
    assign shifted  = {rem_q, quo_q[WIDTH-1]};
    assign fits     = (shifted >= {1'b0, dvs_q});
    assign step_rem = fits ? (shifted[WIDTH-1:0] - dvs_q) : shifted[WIDTH-1:0];
    assign step_quo = {quo_q[WIDTH-2:0], fits};

    div_negate #(.WIDTH(WIDTH)) u_neg_quotient (
        .value_i  (step_quo),
        .enable_i (q_neg_q),
        .result_o (quo_fix)
    );

    div_negate #(.WIDTH(WIDTH)) u_neg_remainder (
        .value_i  (step_rem),
        .enable_i (r_neg_q),
        .result_o (rem_fix)
    );

    // Next-state and datapath control. Normal results are sign-fixed and
    // loaded as the last iteration retires, so valid_o coincides with the FIX
    // cycle; special cases carry their results through FIX and load on exit.
    always_comb begin
        // NOTE: every _d signal gets its hold value first so no path through
        // the case statement can leave one unassigned and infer a latch.
        state_d     = state_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvs_d       = dvs_q;
        cnt_d       = cnt_q;
        q_neg_d     = q_neg_q;
        r_neg_d     = r_neg_q;
        dz_d        = dz_q;
        ov_d        = ov_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dzflag_d    = dzflag_q;
        vflag_d     = vflag_q;
        valid_d     = 1'b0;

        unique case (state_q)
            DIV_IDLE: begin
                if (start_i) begin
                    dz_d    = 1'b0;
                    ov_d    = 1'b0;
                    q_neg_d = 1'b0;
                    r_neg_d = 1'b0;
                    if (divisor_i == '0) begin
                        quo_d   = '1;
                        rem_d   = dividend_i;
                        dz_d    = 1'b1;
                        state_d = DIV_FIX;
                    end else if (signed_i && dividend_i == MOST_NEG && divisor_i == '1) begin
                        quo_d   = dividend_i;
                        rem_d   = '0;
                        ov_d    = 1'b1;
                        state_d = DIV_FIX;
                    end else begin
                        quo_d   = dvd_mag;
                        dvs_d   = dvs_mag;
                        rem_d   = '0;
                        q_neg_d = signed_i & (dividend_i[WIDTH-1] ^ divisor_i[WIDTH-1]);
                        r_neg_d = signed_i & dividend_i[WIDTH-1];
                        cnt_d   = CW'(WIDTH - 1);
                        state_d = DIV_RUN;
                    end
                end
            end
            DIV_RUN: begin
                rem_d = step_rem;
                quo_d = step_quo;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == '0) begin
                    quotient_d  = quo_fix;
                    remainder_d = rem_fix;
                    dzflag_d    = 1'b0;
                    vflag_d     = 1'b0;
                    valid_d     = 1'b1;
                    state_d     = DIV_FIX;
                end
            end
            DIV_FIX: begin
                if (dz_q || ov_q) begin
                    quotient_d  = quo_q;
                    remainder_d = rem_q;
                    dzflag_d    = dz_q;
                    vflag_d     = ov_q;
                    valid_d     = 1'b1;
                end
                state_d = DIV_IDLE;
            end
            default: state_d = DIV_IDLE;
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        // NOTE: non-blocking assignments keep every register sampling the
        // pre-edge values, independent of statement order.
        if (!reset_ni) begin
            state_q     <= DIV_IDLE;
            rem_q       <= '0;
            quo_q       <= '0;
            dvs_q       <= '0;
            cnt_q       <= '0;
            q_neg_q     <= 1'b0;
            r_neg_q     <= 1'b0;
            dz_q        <= 1'b0;
            ov_q        <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dzflag_q    <= 1'b0;
            vflag_q     <= 1'b0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dvs_q       <= dvs_d;
            cnt_q       <= cnt_d;
            q_neg_q     <= q_neg_d;
            r_neg_q     <= r_neg_d;
            dz_q        <= dz_d;
            ov_q        <= ov_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dzflag_q    <= dzflag_d;
            vflag_q     <= vflag_d;
            valid_q     <= valid_d;
        end
    end

    assign busy_o      = (state_q != DIV_IDLE);
    assign valid_o     = valid_q;
    assign quotient_o  = quotient_q;
    assign remainder_o = remainder_q;
    assign dzflag_o    = dzflag_q;
    assign vflag_o     = vflag_q;

endmodule : divider

// File: tb/tb_divider.sv
// Self-checking bench for divider: directed cases, held-start back-to-back,
// mid-run reset and a random soak, all against a plain-arithmetic model.
module tb_divider;

    localparam int W = 64;
    localparam logic [W-1:0] MOST_NEG = 64'h8000_0000_0000_0000;

    logic         clk_i = 1'b0;
    logic         reset_ni;
    logic         start_i;
    logic         signed_i;
    logic [W-1:0] dividend_i;
    logic [W-1:0] divisor_i;
    logic         busy_o;
    logic         valid_o;
    logic [W-1:0] quotient_o;
    logic [W-1:0] remainder_o;
    logic         dzflag_o;
    logic         vflag_o;

    int n_pass  = 0;
    int n_total = 0;

    divider #(.WIDTH(W)) dut (
        .clk_i       (clk_i),
        .reset_ni    (reset_ni),
        .start_i     (start_i),
        .signed_i    (signed_i),
        .dividend_i  (dividend_i),
        .divisor_i   (divisor_i),
        .busy_o      (busy_o),
        .valid_o     (valid_o),
        .quotient_o  (quotient_o),
        .remainder_o (remainder_o),
        .dzflag_o    (dzflag_o),
        .vflag_o     (vflag_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, passed=%0d total=%0d", n_pass, n_total);
        $fatal(1, "watchdog expired");
    end

    // Reference: language-level division plus the two special cases.
    function automatic void ref_div(input bit sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                                    output logic [W-1:0] q, output logic [W-1:0] r,
                                    output logic dz, output logic v);
        dz = 1'b0;
        v  = 1'b0;
        if (b == '0) begin
            q  = '1;
            r  = a;
            dz = 1'b1;
        end else if (sgn && a == MOST_NEG && b == '1) begin
            q = a;
            r = '0;
            v = 1'b1;
        end else if (sgn) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    function automatic logic [W-1:0] mag(input logic [W-1:0] x);
        return x[W-1] ? -x : x;
    endfunction

    // Drives one start and observes it. lat counts falling edges after the
    // accepting edge until valid_o is seen (-1 if it never appears).
    task automatic run_div(input bit sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                           output logic [W-1:0] q, output logic [W-1:0] r,
                           output logic dz, output logic v, output int lat,
                           output logic busy_first, output logic busy_at_valid,
                           output logic busy_after);
        @(negedge clk_i);
        signed_i   = sgn;
        dividend_i = a;
        divisor_i  = b;
        start_i    = 1'b1;
        @(negedge clk_i);
        start_i    = 1'b0;
        dividend_i = {$urandom, $urandom};
        divisor_i  = {$urandom, $urandom};
        signed_i   = ~sgn;
        busy_first = busy_o;
        lat = -1;
        q = 'x; r = 'x; dz = 1'bx; v = 1'bx; busy_at_valid = 1'bx;
        for (int k = 1; k <= W + 8; k++) begin
            @(negedge clk_i);
            if (valid_o) begin
                lat = k;
                q = quotient_o;
                r = remainder_o;
                dz = dzflag_o;
                v = vflag_o;
                busy_at_valid = busy_o;
                break;
            end
        end
        @(negedge clk_i);
        busy_after = busy_o;
    endtask

    task automatic test_reset();
        reset_ni = 1'b0;
        start_i = 1'b1;
        signed_i = 1'b0;
        dividend_i = 64'd100;
        divisor_i = 64'd7;
        repeat (3) @(negedge clk_i);
        n_total++;
        if ({busy_o, valid_o, dzflag_o, vflag_o} !== 4'b0000)
            $display("FAIL reset_ctrl: busy/valid/dz/v=%b required 0000", {busy_o, valid_o, dzflag_o, vflag_o});
        else n_pass++;
        n_total++;
        if (quotient_o !== '0 || remainder_o !== '0)
            $display("FAIL reset_data: q=%h r=%h required 0", quotient_o, remainder_o);
        else n_pass++;
        start_i = 1'b0;
        reset_ni = 1'b1;
        @(negedge clk_i);
    endtask

    typedef struct {
        bit           sgn;
        logic [W-1:0] a;
        logic [W-1:0] b;
    } op_t;

    task automatic check_one(input string tag, input op_t op);
        logic [W-1:0] q, r, eq, er;
        logic dz, v, edz, ev, bf, bv, ba;
        int lat, elat;
        bit special;
        run_div(op.sgn, op.a, op.b, q, r, dz, v, lat, bf, bv, ba);
        ref_div(op.sgn, op.a, op.b, eq, er, edz, ev);
        special = edz | ev;
        elat = special ? 1 : W;
        n_total++;
        if (lat !== elat) $display("FAIL %s latency: got %0d required %0d", tag, lat, elat);
        else n_pass++;
        n_total++;
        if (q !== eq) $display("FAIL %s quotient: got %h required %h", tag, q, eq);
        else n_pass++;
        n_total++;
        if (r !== er) $display("FAIL %s remainder: got %h required %h", tag, r, er);
        else n_pass++;
        n_total++;
        if ({dz, v} !== {edz, ev}) $display("FAIL %s flags dz,v: got %b required %b", tag, {dz, v}, {edz, ev});
        else n_pass++;
        n_total++;
        if ({bf, bv, ba} !== {1'b1, ~special, 1'b0})
            $display("FAIL %s busy first/at-valid/after: got %b required %b", tag, {bf, bv, ba}, {1'b1, ~special, 1'b0});
        else n_pass++;
        if (!special && lat == W) begin
            n_total++;
            if (q * op.b + r !== op.a) $display("FAIL %s identity: q*b+r=%h required %h", tag, q * op.b + r, op.a);
            else n_pass++;
            n_total++;
            if (op.sgn ? !(mag(r) < mag(op.b) && (r == '0 || r[W-1] == op.a[W-1])) : !(r < op.b))
                $display("FAIL %s remainder_bound: r=%h b=%h", tag, r, op.b);
            else n_pass++;
        end
    endtask

    task automatic test_directed();
        op_t ops[6];
        ops[0] = '{1'b0, 64'd100, 64'd7};
        ops[1] = '{1'b1, -64'sd7, 64'd2};
        ops[2] = '{1'b1, 64'd7, -64'sd2};
        ops[3] = '{1'b1, 64'd5, 64'd0};
        ops[4] = '{1'b1, MOST_NEG, '1};
        ops[5] = '{1'b0, MOST_NEG, '1};
        foreach (ops[i]) check_one($sformatf("directed%0d", i), ops[i]);
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] a1, b1, a2, b2, eq1, er1, eq2, er2, q1, r1, q2, r2;
        logic edz, ev;
        int k1, k2;
        a1 = 64'd1_000_003; b1 = 64'd33;
        a2 = -64'sd12345;   b2 = 64'd67;
        ref_div(1'b0, a1, b1, eq1, er1, edz, ev);
        ref_div(1'b1, a2, b2, eq2, er2, edz, ev);
        k1 = -1; k2 = -1;
        q1 = 'x; r1 = 'x; q2 = 'x; r2 = 'x;
        @(negedge clk_i);
        signed_i = 1'b0; dividend_i = a1; divisor_i = b1; start_i = 1'b1;
        @(negedge clk_i);
        signed_i = 1'b1; dividend_i = a2; divisor_i = b2;
        for (int k = 1; k <= 2 * W + 12; k++) begin
            @(negedge clk_i);
            if (k == W + 2) start_i = 1'b0;
            if (valid_o && k1 < 0) begin
                k1 = k; q1 = quotient_o; r1 = remainder_o;
            end else if (valid_o) begin
                k2 = k; q2 = quotient_o; r2 = remainder_o;
                break;
            end
        end
        n_total++;
        if (k1 !== W) $display("FAIL b2b first_latency: got %0d required %0d", k1, W);
        else n_pass++;
        n_total++;
        if ({q1, r1} !== {eq1, er1}) $display("FAIL b2b first_result: got q=%h r=%h required q=%h r=%h", q1, r1, eq1, er1);
        else n_pass++;
        n_total++;
        if (k2 !== 2 * W + 2) $display("FAIL b2b second_latency: got %0d required %0d", k2, 2 * W + 2);
        else n_pass++;
        n_total++;
        if ({q2, r2} !== {eq2, er2}) $display("FAIL b2b second_result: got q=%h r=%h required q=%h r=%h", q2, r2, eq2, er2);
        else n_pass++;
        repeat (2) @(negedge clk_i);
    endtask

    task automatic test_reset_mid();
        int pulses;
        op_t op;
        @(negedge clk_i);
        signed_i = 1'b0; dividend_i = 64'd999; divisor_i = 64'd10; start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (29) @(negedge clk_i);
        reset_ni = 1'b0;
        @(negedge clk_i);
        n_total++;
        if ({busy_o, valid_o, dzflag_o, vflag_o} !== 4'b0000 || quotient_o !== '0 || remainder_o !== '0)
            $display("FAIL midreset_outputs: ctrl=%b q=%h r=%h required all 0",
                     {busy_o, valid_o, dzflag_o, vflag_o}, quotient_o, remainder_o);
        else n_pass++;
        reset_ni = 1'b1;
        pulses = 0;
        repeat (W + 10) begin
            @(negedge clk_i);
            if (valid_o) pulses++;
        end
        n_total++;
        if (pulses !== 0) $display("FAIL midreset_abort: valid pulses %0d required 0", pulses);
        else n_pass++;
        op = '{1'b1, -64'sd1000, 64'd7};
        check_one("after_reset", op);
    endtask

    task automatic test_random();
        op_t op;
        for (int i = 0; i < 40; i++) begin
            op.sgn = 1'($urandom);
            op.a   = {$urandom, $urandom};
            op.b   = {$urandom, $urandom} >> $urandom_range(W - 1, 0);
            case ($urandom_range(15, 0))
                0: op.b = '0;
                1: begin op.a = MOST_NEG; op.b = '1; end
                2: op.b = -op.b;
                default: ;
            endcase
            check_one($sformatf("random%0d", i), op);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_divider
